// File: rtl/oam_dma_pkg.sv
// ============================================================================
// Module : oam_dma_pkg
// Brief  : Shared DMA state type, OAM/DMA address constants, echo-page helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package oam_dma_pkg;

    localparam logic [15:0] OAM_DMA_addr = 16'hFF46;
    localparam logic [15:0] OAM_start    = 16'hFE00;
    localparam int          OAM_len      = 160;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    // E000-FDFF mirrors C000-DDFF, so echo pages fold back by 0x20.
    function automatic logic [7:0] eff_hi(input logic [7:0] hi);
        return (hi >= 8'hE0) ? (hi - 8'h20) : hi;
    endfunction

endpackage

`default_nettype wire

// File: rtl/oam_dma_if.sv
// ============================================================================
// Module : Bus_if
// Brief  : CPU register bus (address, write data/strobe, combinational rdata).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface Bus_if;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        write_en;

    modport master (output addr, output wdata, output write_en, input rdata);
    modport slave  (input addr, input wdata, input write_en, output rdata);
    modport Peripheral_side (input addr, input wdata, input write_en, output rdata);
endinterface

`default_nettype wire

// File: rtl/oam_dma.sv
// ============================================================================
// Module : oam_dma
// Brief  : FF46 register plus paced 160-byte copy from {FF46,00} into OAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int DMA_LEN         = 160
) (
    input  logic           clk,
    input  logic           reset,
    Bus_if.Peripheral_side reg_bus,
    output logic [15:0]    dma_addr,
    output logic           dma_read_en,
    input  logic [7:0]     dma_rdata,
    output logic [7:0]     oam_addr,
    output logic [7:0]     oam_wdata,
    output logic           oam_write_en,
    output logic           dma_active
);

    localparam int            PW       = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;
    localparam logic [PW-1:0] LAST_PH  = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0]    LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_t    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    src_hi_q, src_hi_d;
    logic [15:0]   dma_addr_q, dma_addr_d;
    logic [7:0]    oam_addr_q, oam_addr_d;
    logic          strobe_q, strobe_d;
    logic          active_q;
    logic          ff46_wr;

    assign ff46_wr = reg_bus.write_en && (reg_bus.addr == OAM_DMA_addr);

    // A write in any state restarts; the current strobe is already registered,
    // so a byte whose write clock coincides with the restart still lands.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        src_hi_d = ff46_wr ? reg_bus.wdata : src_hi_q;
        if (ff46_wr) begin
            state_d = START;
            phase_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                START: begin
                    if (phase_q == LAST_PH) begin
                        state_d = XFER;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                XFER: begin
                    if (phase_q == LAST_PH) begin
                        phase_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 8'd1;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        strobe_d   = (state_d == XFER) && (phase_d == LAST_PH);
        dma_addr_d = (state_d == XFER) ? {eff_hi(src_hi_d), idx_d} : 16'h0000;
        oam_addr_d = (state_d == XFER) ? idx_d : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            idx_q      <= '0;
            src_hi_q   <= 8'hFF;
            dma_addr_q <= '0;
            oam_addr_q <= '0;
            strobe_q   <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            src_hi_q   <= src_hi_d;
            dma_addr_q <= dma_addr_d;
            oam_addr_q <= oam_addr_d;
            strobe_q   <= strobe_d;
            active_q   <= (state_d != IDLE);
        end
    end

    always_comb begin
        reg_bus.rdata = (reg_bus.addr == OAM_DMA_addr) ? src_hi_q : 8'hFF;
    end

    assign dma_addr     = dma_addr_q;
    assign oam_addr     = oam_addr_q;
    assign dma_read_en  = strobe_q;
    assign oam_write_en = strobe_q;
    assign dma_active   = active_q;
    assign oam_wdata    = strobe_q ? dma_rdata : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_oam_dma.sv
// ============================================================================
// Module : tb_oam_dma
// Brief  : Directed self-checking bench for oam_dma (CPB=4, 160 bytes).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_oam_dma;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] dma_addr;
    logic        dma_read_en;
    logic [7:0]  dma_rdata;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        oam_write_en;
    logic        dma_active;

    logic [7:0]  mem [0:65535];

    always #5 clk = ~clk;

    Bus_if bus ();

    assign dma_rdata = mem[dma_addr];

    oam_dma #(
        .CYCLES_PER_BYTE (4),
        .DMA_LEN         (160)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .reg_bus      (bus),
        .dma_addr     (dma_addr),
        .dma_read_en  (dma_read_en),
        .dma_rdata    (dma_rdata),
        .oam_addr     (oam_addr),
        .oam_wdata    (oam_wdata),
        .oam_write_en (oam_write_en),
        .dma_active   (dma_active)
    );

    typedef struct {
        int         t;
        logic [7:0] oa;
        logic [7:0] od;
        logic [15:0] sa;
    } wr_t;

    wr_t log_q[$];
    int  cyc        = 0;
    int  active_cnt = 0;
    int  errors     = 0;
    int  checks     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge index recorded is the edge that ends the strobe clock.
    always @(negedge clk) begin
        if (dma_active === 1'b1) active_cnt++;
        if (oam_write_en === 1'b1)
            log_q.push_back('{cyc + 1, oam_addr, oam_wdata, dma_addr});
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic write_ff46(input logic [7:0] v, output int n);
        bus.addr     = 16'hFF46;
        bus.wdata    = v;
        bus.write_en = 1'b1;
        tick();
        bus.write_en = 1'b0;
        n = cyc;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (dma_active && k < limit) begin
            tick();
            k++;
        end
        check("idle_timeout", {31'd0, dma_active}, 32'd0);
    endtask

    task automatic wait_log(input int cnt, input int limit);
        int k = 0;
        while (log_q.size() < cnt && k < limit) begin
            tick();
            k++;
        end
        check("log_timeout", (log_q.size() >= cnt) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Checks entries [base, base+n) as a copy from page pg with pattern key.
    task automatic check_run(input string tag, input int base, input int n,
                             input logic [7:0] pg, input logic [7:0] key);
        for (int k = 0; k < n; k++) begin
            if (base + k < log_q.size()) begin
                check({tag, "_oa"}, log_q[base+k].oa, k);
                check({tag, "_od"}, log_q[base+k].od, k ^ key);
                check({tag, "_sa"}, log_q[base+k].sa, {pg, 8'(k)});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, n2, a0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 160; i++) begin
            mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
            mem[16'hC100 + i] = 8'(i) ^ 8'h33;
            mem[16'hD000 + i] = 8'(i) ^ 8'hA5;
        end
        bus.addr     = 16'h0000;
        bus.wdata    = 8'h00;
        bus.write_en = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_active", {31'd0, dma_active}, 32'd0);
        check("rst_rd_en", {31'd0, dma_read_en}, 32'd0);
        check("rst_wr_en", {31'd0, oam_write_en}, 32'd0);
        check("rst_dma_addr", dma_addr, 32'd0);
        check("rst_oam_addr", oam_addr, 32'd0);
        check("rst_oam_wdata", oam_wdata, 32'd0);
        bus.addr = 16'hFF46;
        #1 check("rst_ff46", bus.rdata, 32'hFF);
        reset = 1'b0;
        tick();

        // Basic copy from C000
        log_q.delete();
        a0 = active_cnt;
        write_ff46(8'hC0, n);
        wait_idle(1000);
        check("basic_count", log_q.size(), 32'd160);
        check_run("basic", 0, 160, 8'hC0, 8'h5A);
        if (log_q.size() >= 160) begin
            check("basic_first_t", log_q[0].t, n + 8);
            check("basic_last_t", log_q[159].t, n + 644);
        end
        check("basic_active", active_cnt - a0, 32'd644);

        // Register readback, including mid-transfer; other addresses read FF
        write_ff46(8'h80, n);
        #1 check("rb_ff46", bus.rdata, 32'h80);
        check("rb_active", {31'd0, dma_active}, 32'd1);
        bus.addr = 16'hFF40;
        #1 check("rb_other", bus.rdata, 32'hFF);
        bus.addr = 16'hFF46;
        repeat (100) tick();
        #1 check("rb_ff46_mid", bus.rdata, 32'h80);
        wait_idle(1000);

        // Echo mapping E1xx -> C1xx
        log_q.delete();
        write_ff46(8'hE1, n);
        wait_idle(1000);
        check("echo_count", log_q.size(), 32'd160);
        check_run("echo", 0, 160, 8'hC1, 8'h33);

        // Restart at byte 50
        log_q.delete();
        a0 = active_cnt;
        write_ff46(8'hC0, n);
        wait_log(50, 1000);
        write_ff46(8'hD0, n2);
        wait_idle(1000);
        check("rs_count", log_q.size(), 32'd210);
        check_run("rs_old", 0, 50, 8'hC0, 8'h5A);
        check_run("rs_new", 50, 160, 8'hD0, 8'hA5);
        if (log_q.size() > 50) check("rs_first_t", log_q[50].t, n2 + 8);
        check("rs_active", active_cnt - a0, (n2 - n) + 644);

        // Reset mid-transfer at byte 80
        log_q.delete();
        write_ff46(8'hC0, n);
        wait_log(80, 1000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_active", {31'd0, dma_active}, 32'd0);
        check("mr_rd_en", {31'd0, dma_read_en}, 32'd0);
        check("mr_wr_en", {31'd0, oam_write_en}, 32'd0);
        check("mr_dma_addr", dma_addr, 32'd0);
        check("mr_oam_addr", oam_addr, 32'd0);
        check("mr_oam_wdata", oam_wdata, 32'd0);
        #1 check("mr_ff46", bus.rdata, 32'hFF);
        repeat (700) tick();
        check("mr_no_writes", log_q.size(), 32'd80);
        log_q.delete();
        write_ff46(8'hC0, n);
        wait_idle(1000);
        check("mr_new_count", log_q.size(), 32'd160);
        check_run("mr_new", 0, 160, 8'hC0, 8'h5A);
        if (log_q.size() > 0) check("mr_new_first_t", log_q[0].t, n + 8);

        // Restart coinciding with byte 159's write clock
        log_q.delete();
        a0 = active_cnt;
        write_ff46(8'hC0, n);
        while (cyc < n + 643) tick();
        write_ff46(8'hD0, n2);
        wait_idle(1000);
        check("bd_count", log_q.size(), 32'd320);
        check_run("bd_old", 0, 160, 8'hC0, 8'h5A);
        check_run("bd_new", 160, 160, 8'hD0, 8'hA5);
        if (log_q.size() > 160) begin
            check("bd_last_t", log_q[159].t, n + 644);
            check("bd_new_first_t", log_q[160].t, n + 652);
        end
        check("bd_active", active_cnt - a0, 32'd1288);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
